acs_sched: RTL and testbench
============================

ACS_SCHED -- requirements
Module: acs_sched

Interface
REQ-001: The module SHALL have parameter RR, default 1, selecting arbitration: 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: vld0, vld1  input  1 each  request valid for requester 0 and requester 1.
REQ-005: a0, b0, a1, b1  input  4 each  operands for requester 0 and requester 1.
REQ-006: sub0, sub1  input  1 each  operation select: 0 = add, 1 = subtract.
REQ-007: rdy0, rdy1  output  1 each  grant; the request is accepted in any cycle where vldN and rdyN are both high.
REQ-008: res  output  4  registered result.
REQ-009: cout  output  1  registered carry out; on subtract, 1 means no borrow.
REQ-010: res_id  output  1  index of the requester that owns res.
REQ-011: res_vld  output  1  result valid.
REQ-012: res_rdy  input  1  downstream accepts the result in any cycle where res_vld and res_rdy are both high.

Function
REQ-013: The module SHALL arbitrate one shared 4-bit add/subtract datapath between two requesters, with a two-state output FSM: EMPTY (res_vld=0) and FULL (res_vld=1).
REQ-014: The output slot is free when the FSM is EMPTY, or when it is FULL and res_rdy=1 in the same cycle.
REQ-015: rdyN SHALL be combinational; it is high only when the slot is free, vldN=1, and requester N wins arbitration. At most one rdy is high in any cycle.
REQ-016: Arbitration SHALL work as follows.
- Only one valid: that requester wins.
- Both valid, RR=1: the requester not granted last wins.
- Both valid, RR=0: requester 0 always wins.
REQ-017: The last-grant pointer SHALL update only on an accepted grant and SHALL NOT change while the slot is blocked.
REQ-018: On an accept, the following SHALL be loaded at the next edge, giving 1-cycle latency from accept to res_vld:
- res = (a + (b XOR {4{sub}}) + sub) mod 16.
- cout = carry out of bit 3.
- res_id = winner index.
- FSM goes to FULL.
REQ-019: In FULL with res_rdy=1 and a new accept, the FSM SHALL stay FULL and load the new result. Sustained throughput is one operation per cycle.
REQ-020: In FULL with res_rdy=1 and no accept, the FSM SHALL go to EMPTY. res, cout and res_id hold their last values.
REQ-021: In FULL with res_rdy=0, all outputs SHALL be held stable and rdy0 = rdy1 = 0.
REQ-022: A requester SHALL hold vldN and its operands stable until accepted. The block does not check this.

Reset
REQ-023: While rst is high, and asynchronously on its assertion, the following SHALL be reset:
- res = 0, cout = 0, res_id = 0, res_vld = 0.
- FSM = EMPTY.
- Last-grant pointer = 1, so requester 0 wins the first contended cycle.
REQ-024: rdy0 and rdy1 SHALL be forced to 0 while rst is high.
REQ-025: Reset asserted while FULL SHALL drop the pending result without delivering it.

Configuration
REQ-026: With macro ACS_SCHED_OVF_EN defined, output ovf (1 bit) SHALL exist and be registered with res.
- ovf = 1 when a[3] equals (b XOR sub)[3] and res[3] differs from a[3] (two's-complement overflow).
- ovf is reset to 0 and held under backpressure like res.
REQ-027: Without ACS_SCHED_OVF_EN, the port and its logic SHALL be absent. All other behaviour is unchanged.

Structure
REQ-028: A shared package acs_pkg SHALL hold:
- Constant ACS_W = 4.
- Typedef for the requester index.
- FSM state enum {ST_EMPTY, ST_FULL}.
REQ-029: Arbitration SHALL live in sub-module acs_rr_arb2, containing the requests, the RR parameter, the pointer and the one-hot grant. The datapath SHALL instantiate the team's existing 4-bit add/subtract unit.

Verification
REQ-030: vld0=1, a0=5, b0=3, sub0=0 -> next cycle: res_vld=1, res=8, cout=0, res_id=0, ovf=1.
REQ-031: Subtract cases:
- vld1=1, a1=5, b1=3, sub1=1 -> res=2, cout=1, res_id=1.
- a1=3, b1=5, sub1=1 -> res=0xE, cout=0.
REQ-032: Both valid for 6 cycles, RR=1, res_rdy=1 -> res_id sequence 0,1,0,1,0,1 with one result per cycle. The same stimulus with RR=0 -> all 0.
REQ-033: Result FULL with res_rdy=0 for 3 cycles, both valid -> rdy0 = rdy1 = 0, and res/res_id stable. Then res_rdy=1 -> the next accept happens in that same cycle.
REQ-034: Assert rst while res_vld=1 and requests pending -> all outputs 0 immediately. After release, requester 0 wins the first contended cycle.

Source files
------------

// File: rtl/acs_pkg.sv
// Shared constants and types for the two-requester add/subtract scheduler.
package acs_pkg;

    localparam int ACS_W = 4;

    typedef logic acs_id_t;

    typedef enum logic {ST_EMPTY, ST_FULL} acs_st_e;

    typedef struct packed {
        logic [ACS_W-1:0] a;
        logic [ACS_W-1:0] b;
        logic             sub;
    } acs_req_t;

    // Two's-complement overflow from the sign bits of the effective operands and result.
    function automatic logic acs_ovf(input logic a_msb, input logic b_msb,
                                     input logic sub, input logic res_msb);
        return (a_msb == (b_msb ^ sub)) && (res_msb != a_msb);
    endfunction

endpackage

// File: rtl/acs_addsub4.sv
// Shared ACS_W-bit add/subtract unit: s = a + (b ^ {sub}) + sub, with carry out.
module acs_addsub4
    import acs_pkg::*;
(
    input  logic [ACS_W-1:0] a_i,
    input  logic [ACS_W-1:0] b_i,
    input  logic             sub_i,
    output logic [ACS_W-1:0] s_o,
    output logic             cout_o
);

    logic [ACS_W:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i ^ {ACS_W{sub_i}}} + {{ACS_W{1'b0}}, sub_i};
    assign {cout_o, s_o} = sum;

endmodule

// File: rtl/acs_rr_arb2.sv
// Two-way arbiter: round-robin (RR=1) or fixed priority to requester 0 (RR=0).
module acs_rr_arb2
    import acs_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output acs_id_t    win_o
);

    acs_id_t last_q, last_d;

    always_comb begin
        win_o = 1'b0;
        case (req_i)
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = (RR != 0) ? ~last_q : 1'b0;
            default: win_o = 1'b0;
        endcase
        gnt_o = 2'b00;
        if (en_i && (|req_i)) begin
            gnt_o[win_o] = 1'b1;
        end
        // Pointer only moves on an actual grant, so a blocked slot keeps fairness state.
        last_d = (|gnt_o) ? win_o : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/acs_sched.sv
// Arbitrates one shared add/subtract datapath between two requesters into a one-entry output slot.
// Optional ovf output enabled by defining ACS_SCHED_OVF_EN.
module acs_sched
    import acs_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld0,
    input  logic             vld1,
    input  logic [ACS_W-1:0] a0,
    input  logic [ACS_W-1:0] b0,
    input  logic [ACS_W-1:0] a1,
    input  logic [ACS_W-1:0] b1,
    input  logic             sub0,
    input  logic             sub1,
    output logic             rdy0,
    output logic             rdy1,
    output logic [ACS_W-1:0] res,
    output logic             cout,
    output acs_id_t          res_id,
`ifdef ACS_SCHED_OVF_EN
    output logic             ovf,
`endif
    output logic             res_vld,
    input  logic             res_rdy
);

    acs_st_e          st_q, st_d;
    logic             free;
    logic             acc;
    logic [1:0]       gnt;
    acs_id_t          win;
    acs_req_t [1:0]   reqs;
    acs_req_t         sel;
    logic [ACS_W-1:0] sum_s;
    logic             sum_c;

    logic [ACS_W-1:0] res_q;
    logic             cout_q;
    acs_id_t          id_q;

    // Slot frees up in the same cycle the downstream drains it.
    assign free = (st_q == ST_EMPTY) || res_rdy;

    acs_rr_arb2 #(.RR(RR)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({vld1, vld0}),
        .en_i  (free && !rst),
        .gnt_o (gnt),
        .win_o (win)
    );

    assign rdy0 = gnt[0];
    assign rdy1 = gnt[1];
    assign acc  = |gnt;

    assign reqs[0] = {a0, b0, sub0};
    assign reqs[1] = {a1, b1, sub1};
    assign sel     = reqs[win];

    acs_addsub4 u_alu (
        .a_i    (sel.a),
        .b_i    (sel.b),
        .sub_i  (sel.sub),
        .s_o    (sum_s),
        .cout_o (sum_c)
    );

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_EMPTY: if (acc) st_d = ST_FULL;
            ST_FULL:  if (res_rdy) st_d = acc ? ST_FULL : ST_EMPTY;
            default:  st_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= ST_EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            id_q   <= 1'b0;
        end else if (acc) begin
            res_q  <= sum_s;
            cout_q <= sum_c;
            id_q   <= win;
        end
    end

`ifdef ACS_SCHED_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (acc) begin
            ovf_q <= acs_ovf(sel.a[ACS_W-1], sel.b[ACS_W-1], sel.sub, sum_s[ACS_W-1]);
        end
    end

    assign ovf = ovf_q;
`endif

    assign res     = res_q;
    assign cout    = cout_q;
    assign res_id  = id_q;
    assign res_vld = (st_q == ST_FULL);

endmodule

// File: tb/tb_acs_sched.sv
// Bench for acs_sched: RR=1 and RR=0 instances checked against an arithmetic reference model.
module tb_acs_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       vld0[2], vld1[2], sub0[2], sub1[2], res_rdy[2];
    logic [3:0] a0[2], b0[2], a1[2], b1[2];
    logic       rdy0[2], rdy1[2], cout[2], res_id[2], res_vld[2];
    logic [3:0] res[2];
`ifdef ACS_SCHED_OVF_EN
    logic       ovf[2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: slot contents, fullness and who was granted last.
    bit       m_full[2], m_cout[2], m_id[2], m_ovf[2], m_last[2], m_acc0[2], m_acc1[2];
    bit [3:0] m_res[2];
    int       rrp[2] = '{1, 0};

    acs_sched #(.RR(1)) u_rr (
        .clk(clk), .rst(rst), .vld0(vld0[0]), .vld1(vld1[0]),
        .a0(a0[0]), .b0(b0[0]), .a1(a1[0]), .b1(b1[0]), .sub0(sub0[0]), .sub1(sub1[0]),
        .rdy0(rdy0[0]), .rdy1(rdy1[0]), .res(res[0]), .cout(cout[0]), .res_id(res_id[0]),
`ifdef ACS_SCHED_OVF_EN
        .ovf(ovf[0]),
`endif
        .res_vld(res_vld[0]), .res_rdy(res_rdy[0])
    );

    acs_sched #(.RR(0)) u_fp (
        .clk(clk), .rst(rst), .vld0(vld0[1]), .vld1(vld1[1]),
        .a0(a0[1]), .b0(b0[1]), .a1(a1[1]), .b1(b1[1]), .sub0(sub0[1]), .sub1(sub1[1]),
        .rdy0(rdy0[1]), .rdy1(rdy1[1]), .res(res[1]), .cout(cout[1]), .res_id(res_id[1]),
`ifdef ACS_SCHED_OVF_EN
        .ovf(ovf[1]),
`endif
        .res_vld(res_vld[1]), .res_rdy(res_rdy[1])
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 0; m_res[k] = 0; m_cout[k] = 0; m_id[k] = 0; m_ovf[k] = 0;
            m_last[k] = 1; m_acc0[k] = 0; m_acc1[k] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), 8'(res_vld[k]), 8'd0);
            chk($sformatf("%s_res%0d", tag, k), 8'(res[k]), 8'd0);
            chk($sformatf("%s_cout%0d", tag, k), 8'(cout[k]), 8'd0);
            chk($sformatf("%s_id%0d", tag, k), 8'(res_id[k]), 8'd0);
            chk($sformatf("%s_rdy%0d", tag, k), 8'({rdy1[k], rdy0[k]}), 8'd0);
`ifdef ACS_SCHED_OVF_EN
            chk($sformatf("%s_ovf%0d", tag, k), 8'(ovf[k]), 8'd0);
`endif
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit       free, acc, win, ws;
            bit [3:0] wa, wb;
            int       u, sa, sb, r;
            free = !m_full[k] || res_rdy[k];
            if (vld0[k] && vld1[k]) win = (rrp[k] != 0) ? !m_last[k] : 1'b0;
            else                    win = vld1[k];
            acc = free && (vld0[k] || vld1[k]) && !rst;
            chk($sformatf("rdy0_%0d", k), 8'(rdy0[k]), 8'(acc && !win));
            chk($sformatf("rdy1_%0d", k), 8'(rdy1[k]), 8'(acc && win));
            chk($sformatf("res_vld_%0d", k), 8'(res_vld[k]), 8'(m_full[k]));
            chk($sformatf("res_%0d", k), 8'(res[k]), 8'(m_res[k]));
            chk($sformatf("cout_%0d", k), 8'(cout[k]), 8'(m_cout[k]));
            chk($sformatf("res_id_%0d", k), 8'(res_id[k]), 8'(m_id[k]));
`ifdef ACS_SCHED_OVF_EN
            chk($sformatf("ovf_%0d", k), 8'(ovf[k]), 8'(m_ovf[k]));
`endif
            m_acc0[k] = acc && !win;
            m_acc1[k] = acc && win;
            if (acc) begin
                wa = win ? a1[k] : a0[k];
                wb = win ? b1[k] : b0[k];
                ws = win ? sub1[k] : sub0[k];
                u  = ws ? int'(wa) - int'(wb) : int'(wa) + int'(wb);
                m_res[k]  = 4'(u);
                m_cout[k] = ws ? (wa >= wb) : (u > 15);
                sa = wa[3] ? int'(wa) - 16 : int'(wa);
                sb = wb[3] ? int'(wb) - 16 : int'(wb);
                r  = ws ? sa - sb : sa + sb;
                m_ovf[k]  = (r > 7) || (r < -8);
                m_id[k]   = win;
                m_full[k] = 1;
                m_last[k] = win;
            end else if (res_rdy[k]) begin
                m_full[k] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int k);
        if (!vld0[k] || m_acc0[k]) begin
            vld0[k] = ($urandom_range(3) != 0);
            a0[k] = 4'($urandom); b0[k] = 4'($urandom); sub0[k] = 1'($urandom);
        end
        if (!vld1[k] || m_acc1[k]) begin
            vld1[k] = ($urandom_range(3) != 0);
            a1[k] = 4'($urandom); b1[k] = 4'($urandom); sub1[k] = 1'($urandom);
        end
        res_rdy[k] = ($urandom_range(3) != 0);
    endtask

    initial begin
        logic [3:0] held_res;
        logic       held_id;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vld0[k] = 0; vld1[k] = 0; sub0[k] = 0; sub1[k] = 0; res_rdy[k] = 1;
            a0[k] = 0; b0[k] = 0; a1[k] = 0; b1[k] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Add from requester 0: 5 + 3
        for (int k = 0; k < 2; k++) begin vld0[k] = 1; a0[k] = 5; b0[k] = 3; sub0[k] = 0; end
        cycle();
        for (int k = 0; k < 2; k++) vld0[k] = 0;
        chk("add_vld", 8'(res_vld[0]), 8'd1);
        chk("add_res", 8'(res[0]), 8'd8);
        chk("add_cout", 8'(cout[0]), 8'd0);
        chk("add_id", 8'(res_id[0]), 8'd0);
`ifdef ACS_SCHED_OVF_EN
        chk("add_ovf", 8'(ovf[0]), 8'd1);
`endif

        // Subtracts from requester 1
        for (int k = 0; k < 2; k++) begin vld1[k] = 1; a1[k] = 5; b1[k] = 3; sub1[k] = 1; end
        cycle();
        chk("sub_res", 8'(res[0]), 8'd2);
        chk("sub_cout", 8'(cout[0]), 8'd1);
        chk("sub_id", 8'(res_id[0]), 8'd1);
        for (int k = 0; k < 2; k++) begin a1[k] = 3; b1[k] = 5; end
        cycle();
        for (int k = 0; k < 2; k++) vld1[k] = 0;
        chk("borrow_res", 8'(res[0]), 8'hE);
        chk("borrow_cout", 8'(cout[0]), 8'd0);

        // Contention with the slot always draining
        for (int k = 0; k < 2; k++) begin
            vld0[k] = 1; a0[k] = 2; b0[k] = 1; sub0[k] = 0;
            vld1[k] = 1; a1[k] = 9; b1[k] = 4; sub1[k] = 1;
            res_rdy[k] = 1;
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("rr_id%0d", i), 8'(res_id[0]), 8'(i % 2));
            chk($sformatf("fp_id%0d", i), 8'(res_id[1]), 8'd0);
            chk($sformatf("rr_vld%0d", i), 8'(res_vld[0]), 8'd1);
        end

        // Backpressure for three cycles, then release
        for (int k = 0; k < 2; k++) res_rdy[k] = 0;
        held_res = res[0];
        held_id  = res_id[0];
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("bp_res%0d", i), 8'(res[0]), 8'(held_res));
            chk($sformatf("bp_id%0d", i), 8'(res_id[0]), 8'(held_id));
            chk($sformatf("bp_rdy%0d", i), 8'({rdy1[0], rdy0[0]}), 8'd0);
        end
        for (int k = 0; k < 2; k++) res_rdy[k] = 1;
        #1;
        chk("bp_release", 8'(rdy0[0] | rdy1[0]), 8'd1);
        cycle();

        // Reset while full with both requests pending
        for (int k = 0; k < 2; k++) res_rdy[k] = 0;
        @(negedge clk);
        chk("pre_rst_vld", 8'(res_vld[0]), 8'd1);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) res_rdy[k] = 1;
        cycle();
        chk("post_rst_id_rr", 8'(res_id[0]), 8'd0);
        chk("post_rst_id_fp", 8'(res_id[1]), 8'd0);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 2; k++) begin vld0[k] = 0; vld1[k] = 0; end
        repeat (500) begin
            drive_rand(0);
            drive_rand(1);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
